lvt_bram_exerciser: RTL and testbench



---
 rtl/lvt_bist_pkg.sv | 29 ++
 rtl/lvt_rd_checker.sv | 81 ++++++++
 rtl/lvt_bram_exerciser.sv | 233 +++++++++++++++++++++++
 tb/tb_lvt_bram_exerciser.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvt_bist_pkg.sv
//-----------------------------------------------------------------------------
// Module      : lvt_bist_pkg
// Description : Shared state encoding, data-pattern function and constants
//               for the lvt_bram exerciser.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package lvt_bist_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_OVR   = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_e;

  // Callers zero-extend the address into the 64-bit operand and truncate the result.
  function automatic logic [63:0] pat_d(input logic [63:0] addr, input logic [63:0] pat);
    return addr ^ pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lvt_rd_checker.sv
//-----------------------------------------------------------------------------
// Module      : lvt_rd_checker
// Description : Read-latency address pipe, expected-value compare, saturating
//               error counter and first-error address latch.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module lvt_rd_checker
  import lvt_bist_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] PAT1       = 'hA5,
  parameter logic [DATA_WIDTH-1:0] PAT2       = 'h3C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mismatch,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  logic [RD_LATENCY-1:0] r_vld;
  logic [ADDR_WIDTH-1:0] r_addr [RD_LATENCY];
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;

  logic [ADDR_WIDTH-1:0] w_exit_addr;
  logic [DATA_WIDTH-1:0] w_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_vld[0]  <= issue & ~clear;
      r_addr[0] <= issue_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1] & ~clear;
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  // Odd words keep their fill value; even words end with the port-1 overwrite.
  assign w_exit_addr = r_addr[RD_LATENCY-1];
  assign w_exp       = w_exit_addr[0] ? DATA_WIDTH'(pat_d(64'(w_exit_addr), 64'(PAT1)))
                                      : DATA_WIDTH'(pat_d(64'(w_exit_addr), 64'(PAT2)));
  assign mismatch    = r_vld[RD_LATENCY-1] && (rd_data != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (clear) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (mismatch) begin
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
      if (r_err_count == '0) begin
        r_first_err_addr <= w_exit_addr;
      end
    end
  end

  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;

endmodule

`default_nettype wire

// File: rtl/lvt_bram_exerciser.sv
//-----------------------------------------------------------------------------
// Module      : lvt_bram_exerciser
// Description : Fill / same-address overwrite / readback BIST sequencer for a
//               2-write 1-read live-value-table memory.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module lvt_bram_exerciser
  import lvt_bist_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_WORDS  = 64,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] PAT0       = 'h5A,
  parameter logic [DATA_WIDTH-1:0] PAT1       = 'hA5,
  parameter logic [DATA_WIDTH-1:0] PAT2       = 'h3C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] wr0_addr,
  output logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_en,
  output logic [ADDR_WIDTH-1:0] wr1_addr,
  output logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_en,
  output logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_en,
  input  logic [DATA_WIDTH-1:0] rd0_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  // Headroom so the counter also covers the drain phase for narrow address widths.
  localparam int                 c_CNT_W      = ADDR_WIDTH + 3;
  localparam logic [c_CNT_W-1:0] c_FILL_LAST  = c_CNT_W'(NUM_WORDS / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_WORD_LAST  = c_CNT_W'(NUM_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(RD_LATENCY - 1);

  function automatic logic [DATA_WIDTH-1:0] dat(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] p);
    return DATA_WIDTH'(pat_d(64'(a), 64'(p)));
  endfunction

  bist_state_e           r_state, w_state_n;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_n;
  logic                  w_start_go;

  logic [ADDR_WIDTH-1:0] w_even_addr, w_pair_addr;
  logic [ADDR_WIDTH-1:0] r_wr0_addr, w_wr0_addr, r_wr1_addr, w_wr1_addr, r_rd0_addr, w_rd0_addr;
  logic [DATA_WIDTH-1:0] r_wr0_data, w_wr0_data, r_wr1_data, w_wr1_data;
  logic                  r_wr0_en, w_wr0_en, r_wr1_en, w_wr1_en, r_rd0_en, w_rd0_en;
  logic                  r_busy, w_busy, r_done, w_done, r_pass, w_pass;

  logic                  w_mismatch;
  logic [ERR_CNT_W-1:0]  w_err_count;
  logic [ADDR_WIDTH-1:0] w_first_err_addr;

  assign w_start_go = (r_state == ST_IDLE) && start;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_n = '0;
        if (start) w_state_n = ST_FILL;
      end
      ST_FILL: begin
        w_cnt_n = r_cnt + c_CNT_W'(1);
        if (r_cnt == c_FILL_LAST) begin
          w_state_n = ST_OVR;
          w_cnt_n   = '0;
        end
      end
      ST_OVR: begin
        w_cnt_n = r_cnt + c_CNT_W'(1);
        if (r_cnt == c_WORD_LAST) begin
          w_state_n = ST_READ;
          w_cnt_n   = '0;
        end
      end
      ST_READ: begin
        w_cnt_n = r_cnt + c_CNT_W'(1);
        if (r_cnt == c_WORD_LAST) begin
          w_state_n = ST_DRAIN;
          w_cnt_n   = '0;
        end
      end
      ST_DRAIN: begin
        w_cnt_n = r_cnt + c_CNT_W'(1);
        if (r_cnt == c_DRAIN_LAST) begin
          w_state_n = ST_DONE;
          w_cnt_n   = '0;
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Port outputs are decoded from the next state so they are registered yet aligned with it.
  assign w_even_addr = ADDR_WIDTH'(w_cnt_n << 1);
  assign w_pair_addr = ADDR_WIDTH'(w_cnt_n & ~c_CNT_W'(1));

  always_comb begin
    w_wr0_en   = 1'b0;
    w_wr0_addr = '0;
    w_wr0_data = '0;
    w_wr1_en   = 1'b0;
    w_wr1_addr = '0;
    w_wr1_data = '0;
    w_rd0_en   = 1'b0;
    w_rd0_addr = '0;
    case (w_state_n)
      ST_FILL: begin
        w_wr0_en   = 1'b1;
        w_wr0_addr = w_even_addr;
        w_wr0_data = dat(w_even_addr, PAT0);
        w_wr1_en   = 1'b1;
        w_wr1_addr = w_even_addr | ADDR_WIDTH'(1);
        w_wr1_data = dat(w_even_addr | ADDR_WIDTH'(1), PAT1);
      end
      ST_OVR: begin
        if (!w_cnt_n[0]) begin
          w_wr0_en   = 1'b1;
          w_wr0_addr = w_pair_addr;
          w_wr0_data = dat(w_pair_addr, PAT1);
        end else begin
          w_wr1_en   = 1'b1;
          w_wr1_addr = w_pair_addr;
          w_wr1_data = dat(w_pair_addr, PAT2);
        end
      end
      ST_READ: begin
        w_rd0_en   = 1'b1;
        w_rd0_addr = ADDR_WIDTH'(w_cnt_n);
      end
      default: ;
    endcase
  end

  assign w_busy = (w_state_n != ST_IDLE);
  assign w_done = (w_state_n == ST_DONE);

  // The final compare can land in the last drain cycle, so fold in this cycle's mismatch.
  always_comb begin
    w_pass = r_pass;
    if (w_start_go) begin
      w_pass = 1'b0;
    end else if (w_state_n == ST_DONE) begin
      w_pass = (w_err_count == '0) && !w_mismatch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wr0_en   <= 1'b0;
      r_wr0_addr <= '0;
      r_wr0_data <= '0;
      r_wr1_en   <= 1'b0;
      r_wr1_addr <= '0;
      r_wr1_data <= '0;
      r_rd0_en   <= 1'b0;
      r_rd0_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_wr0_en   <= w_wr0_en;
      r_wr0_addr <= w_wr0_addr;
      r_wr0_data <= w_wr0_data;
      r_wr1_en   <= w_wr1_en;
      r_wr1_addr <= w_wr1_addr;
      r_wr1_data <= w_wr1_data;
      r_rd0_en   <= w_rd0_en;
      r_rd0_addr <= w_rd0_addr;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pass     <= w_pass;
    end
  end

  lvt_rd_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .PAT1       (PAT1),
    .PAT2       (PAT2)
  ) u_rd_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (w_start_go),
    .issue          (r_rd0_en),
    .issue_addr     (r_rd0_addr),
    .rd_data        (rd0_data),
    .mismatch       (w_mismatch),
    .err_count      (w_err_count),
    .first_err_addr (w_first_err_addr)
  );

  assign wr0_addr       = r_wr0_addr;
  assign wr0_data       = r_wr0_data;
  assign wr0_en         = r_wr0_en;
  assign wr1_addr       = r_wr1_addr;
  assign wr1_data       = r_wr1_data;
  assign wr1_en         = r_wr1_en;
  assign rd0_addr       = r_rd0_addr;
  assign rd0_en         = r_rd0_en;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = w_err_count;
  assign first_err_addr = w_first_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_lvt_bram_exerciser.sv
//-----------------------------------------------------------------------------
// Module      : tb_lvt_bram_exerciser
// Description : Two exercisers (read latency 1 and 3) against behavioural
//               2W1R LVT memories, with a done-event scoreboard.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_lvt_bram_exerciser;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NW = 8;

  typedef struct {
    int          done_cyc;
    logic        pass;
    logic [15:0] errs;
    logic [7:0]  ferr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n;
  logic          start_s    [2];
  logic [AW-1:0] wr0_addr_s [2];
  logic [AW-1:0] wr1_addr_s [2];
  logic [AW-1:0] rd0_addr_s [2];
  logic [AW-1:0] ferr_s     [2];
  logic [DW-1:0] wr0_data_s [2];
  logic [DW-1:0] wr1_data_s [2];
  logic [DW-1:0] rd0_data_s [2];
  logic          wr0_en_s   [2];
  logic          wr1_en_s   [2];
  logic          rd0_en_s   [2];
  logic          busy_s     [2];
  logic          done_s     [2];
  logic          pass_s     [2];
  logic [15:0]   errc_s     [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   fault0  = 0;
  exp_t q0[$];
  exp_t q1[$];

  lvt_bram_exerciser #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .RD_LATENCY(1),
    .PAT0(8'h5A), .PAT1(8'hA5), .PAT2(8'h3C)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .wr0_addr(wr0_addr_s[0]), .wr0_data(wr0_data_s[0]), .wr0_en(wr0_en_s[0]),
    .wr1_addr(wr1_addr_s[0]), .wr1_data(wr1_data_s[0]), .wr1_en(wr1_en_s[0]),
    .rd0_addr(rd0_addr_s[0]), .rd0_en(rd0_en_s[0]), .rd0_data(rd0_data_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(errc_s[0]), .first_err_addr(ferr_s[0])
  );

  lvt_bram_exerciser #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .RD_LATENCY(3),
    .PAT0(8'h5A), .PAT1(8'hA5), .PAT2(8'h3C)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .wr0_addr(wr0_addr_s[1]), .wr0_data(wr0_data_s[1]), .wr0_en(wr0_en_s[1]),
    .wr1_addr(wr1_addr_s[1]), .wr1_data(wr1_data_s[1]), .wr1_en(wr1_en_s[1]),
    .rd0_addr(rd0_addr_s[1]), .rd0_en(rd0_en_s[1]), .rd0_data(rd0_data_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(errc_s[1]), .first_err_addr(ferr_s[1])
  );

  // Behavioural 2W1R LVT memory: two banks plus a table naming the last writer.
  logic [DW-1:0] bank0 [2][256];
  logic [DW-1:0] bank1 [2][256];
  logic          lvt   [2][256];
  logic [DW-1:0] rpipe [2][4];

  function automatic logic [DW-1:0] model_rd(input int i, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = lvt[i][a] ? bank1[i][a] : bank0[i][a];
    if (i == 0 && fault0 == 1) v = bank0[i][a];
    if (i == 0 && fault0 == 2 && a == 8'd3) v = v ^ 8'h01;
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int a = 0; a < 256; a++) begin
          bank0[i][a] <= '0;
          bank1[i][a] <= '0;
          lvt[i][a]   <= 1'b0;
        end
        for (int k = 0; k < 4; k++) rpipe[i][k] <= '0;
      end else begin
        if (wr0_en_s[i]) begin
          bank0[i][wr0_addr_s[i]] <= wr0_data_s[i];
          lvt[i][wr0_addr_s[i]]   <= 1'b0;
        end
        if (wr1_en_s[i]) begin
          bank1[i][wr1_addr_s[i]] <= wr1_data_s[i];
          lvt[i][wr1_addr_s[i]]   <= 1'b1;
        end
        rpipe[i][0] <= model_rd(i, rd0_addr_s[i]);
        for (int k = 1; k < 4; k++) rpipe[i][k] <= rpipe[i][k-1];
      end
    end
  end

  assign rd0_data_s[0] = rpipe[0][0];
  assign rd0_data_s[1] = rpipe[1][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int i);
    exp_t e;
    bit   empty;
    empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_done inst%0d at cycle %0d", i, cyc);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("done_cycle[%0d]", i), cyc, e.done_cyc);
      chk($sformatf("pass[%0d]", i), 32'(pass_s[i]), 32'(e.pass));
      chk($sformatf("err_count[%0d]", i), 32'(errc_s[i]), 32'(e.errs));
      chk($sformatf("first_err_addr[%0d]", i), 32'(ferr_s[i]), 32'(e.ferr));
      chk($sformatf("busy_at_done[%0d]", i), 32'(busy_s[i]), 32'd1);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_s[i] === 1'b1) check_done(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input int dc, input logic p,
                          input logic [15:0] ec, input logic [7:0] fe);
    exp_t e;
    e.done_cyc = dc;
    e.pass     = p;
    e.errs     = ec;
    e.ferr     = fe;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after an edge: start is sampled at the next edge, FILL begins in cyc+1,
  // and done lands NUM_WORDS/2 + 2*NUM_WORDS + RD_LATENCY cycles after that.
  task automatic launch(input int i, input bit expect_done, input logic p,
                        input logic [15:0] ec, input logic [7:0] fe);
    start_s[i] = 1'b1;
    if (expect_done) push_exp(i, cyc + 1 + NW / 2 + 2 * NW + ((i == 0) ? 1 : 3), p, ec, fe);
  endtask

  task automatic wait_runs();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("run_timeout_pending", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete();
    q1.delete();
    tick();
    tick();
  endtask

  int k;

  initial begin
    rst_n      = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ctrl[%0d]", i),
          32'({busy_s[i], done_s[i], pass_s[i], wr0_en_s[i], wr1_en_s[i], rd0_en_s[i]}), 32'd0);
      chk($sformatf("reset_addr[%0d]", i),
          {wr0_addr_s[i], wr1_addr_s[i], rd0_addr_s[i], ferr_s[i]}, 32'd0);
      chk($sformatf("reset_data[%0d]", i), 32'({wr0_data_s[i], wr1_data_s[i], errc_s[i]}), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    tick();

    // Healthy run with per-cycle port checks.
    launch(0, 1'b1, 1'b1, 16'd0, 8'd0);
    tick();
    start_s[0] = 1'b0;
    chk("fill_wr0", 32'({wr0_en_s[0], wr0_addr_s[0], wr0_data_s[0]}), 32'({1'b1, 8'h00, 8'h5A}));
    chk("fill_wr1", 32'({wr1_en_s[0], wr1_addr_s[0], wr1_data_s[0]}), 32'({1'b1, 8'h01, 8'hA4}));
    chk("fill_busy_rd", 32'({busy_s[0], rd0_en_s[0]}), 32'b10);
    repeat (4) tick();
    chk("ovr_wr0", 32'({wr0_en_s[0], wr0_addr_s[0], wr0_data_s[0]}), 32'({1'b1, 8'h00, 8'hA5}));
    chk("ovr_wr1_quiet", 32'({wr1_en_s[0], wr1_addr_s[0], wr1_data_s[0]}), 32'd0);
    tick();
    chk("ovr_wr1", 32'({wr1_en_s[0], wr1_addr_s[0], wr1_data_s[0]}), 32'({1'b1, 8'h00, 8'h3C}));
    chk("ovr_wr0_quiet", 32'({wr0_en_s[0], wr0_addr_s[0], wr0_data_s[0]}), 32'd0);
    repeat (8) tick();
    chk("read_first", 32'({rd0_en_s[0], rd0_addr_s[0]}), 32'({1'b1, 8'h01}));
    wait_runs();
    chk("pass_held_idle", 32'({pass_s[0], busy_s[0]}), 32'b10);

    // LVT broken: model always returns bank 0.
    fault0 = 1;
    launch(0, 1'b1, 1'b0, 16'd8, 8'd0);
    tick();
    start_s[0] = 1'b0;
    wait_runs();
    fault0 = 0;

    // Single-bit corruption at address 3.
    fault0 = 2;
    launch(0, 1'b1, 1'b0, 16'd1, 8'd3);
    tick();
    start_s[0] = 1'b0;
    wait_runs();
    fault0 = 0;

    // Start held high: no restart while busy, relaunch one cycle after IDLE.
    k = cyc;
    launch(0, 1'b1, 1'b1, 16'd0, 8'd0);
    repeat (23) tick();
    chk("held_idle_gap", 32'({busy_s[0], wr0_en_s[0]}), 32'b00);
    push_exp(0, k + 24 + NW / 2 + 2 * NW + 1, 1'b1, 16'd0, 8'd0);
    tick();
    chk("held_relaunch", 32'({busy_s[0], wr0_en_s[0], wr0_data_s[0]}), 32'({1'b1, 1'b1, 8'h5A}));
    start_s[0] = 1'b0;
    wait_runs();

    // Reset during READ aborts without a done pulse.
    launch(0, 1'b0, 1'b0, 16'd0, 8'd0);
    tick();
    start_s[0] = 1'b0;
    repeat (14) tick();
    chk("in_read", 32'({busy_s[0], rd0_en_s[0]}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 32'({busy_s[0], done_s[0], pass_s[0], rd0_en_s[0], wr0_en_s[0], wr1_en_s[0]}),
        32'd0);
    chk("abort_errs", 32'({errc_s[0], ferr_s[0], rd0_addr_s[0]}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("abort_idle", 32'({busy_s[0], pass_s[0]}), 32'd0);

    launch(0, 1'b1, 1'b1, 16'd0, 8'd0);
    tick();
    start_s[0] = 1'b0;
    wait_runs();

    // Read latency 3 instance.
    launch(1, 1'b1, 1'b1, 16'd0, 8'd0);
    tick();
    start_s[1] = 1'b0;
    wait_runs();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
